fetch_unit: RTL and testbench

- Instruction-fetch stage for the WISC-SP13 core. Sits directly upstream of the decode/control stage.
- Holds the PC and issues one-outstanding-request reads to instruction memory.
- Buffers returned instructions and presents a valid/stall handshake to decode: instr, PC+2, and the opcode/lower_two fields that drive control decoding.
- Handles branch/jump redirect (flush), HALT, and memory back-pressure.

---
 rtl/fetch_unit.sv | 186 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: WISC-SP13 instruction fetch with one outstanding imem request, a one-entry
// skid buffer, redirect/kill and halt. Define FETCH_ALIGN_CHK_EN to trap misaligned redirects.
module fetch_unit #(
  parameter int unsigned        PC_W      = 16,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [15:0]        NOP_INSTR = 16'h0800
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rdy,
  input  logic            imem_rvalid,
  input  logic [15:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            halt,
  output logic [15:0]     instr,
  output logic [PC_W-1:0] instr_pc,
  output logic [PC_W-1:0] pc_plus2,
  output logic [4:0]      opcode,
  output logic [1:0]      lower_two,
  output logic            instr_valid,
  output logic            halted,
  output logic            err
);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  logic [1:0]      state, state_n;
  logic [PC_W-1:0] pc, pc_n, req_pc, req_pc_n, instr_pc_n, pc_plus2_n, rpc_c;
  logic [15:0]     skid, skid_n, instr_n;
  logic            kill, kill_n, valid_n, halted_n, req_n;
  logic            hs_c, slot_free_c, misalign_c;

  assign imem_addr   = pc;
  assign opcode      = instr[15:11];
  assign lower_two   = instr[1:0];
  assign hs_c        = imem_req & imem_rdy;
  assign slot_free_c = ~instr_valid | ~stall;
  assign rpc_c       = redirect_pc & ~PC_W'(1);

`ifdef FETCH_ALIGN_CHK_EN
  logic err_q;

  // Sticky trap flag for an odd redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state != HALTED && redirect_valid && redirect_pc[0]) begin
      err_q <= 1'b1;
    end
  end

  assign err        = err_q;
  assign misalign_c = redirect_pc[0];
`else
  assign err        = 1'b0;
  assign misalign_c = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      req_pc      <= '0;
      kill        <= 1'b0;
      skid        <= NOP_INSTR;
      instr       <= NOP_INSTR;
      instr_pc    <= '0;
      pc_plus2    <= PC_W'(2);
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      imem_req    <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      req_pc      <= req_pc_n;
      kill        <= kill_n;
      skid        <= skid_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      pc_plus2    <= pc_plus2_n;
      instr_valid <= valid_n;
      halted      <= halted_n;
      imem_req    <= req_n;
    end
  end

  // Next-state: redirect beats halt, halt beats normal sequencing.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_pc_n   = req_pc;
    kill_n     = kill;
    skid_n     = skid;
    instr_n    = instr;
    instr_pc_n = instr_pc;
    valid_n    = instr_valid;
    halted_n   = halted;

    // Decode takes the word; the slot empties unless refilled below.
    if (instr_valid && !stall) begin
      valid_n = 1'b0;
      instr_n = NOP_INSTR;
    end

    if (state != HALTED) begin
      if (redirect_valid) begin
        valid_n = 1'b0;
        instr_n = NOP_INSTR;
        kill_n  = 1'b0;
        if (misalign_c) begin
          halted_n = 1'b1;
          state_n  = HALTED;
        end else begin
          pc_n = rpc_c;
          case (state)
            FETCH: begin
              if (hs_c) begin
                state_n = WAIT;
                kill_n  = 1'b1;
              end
            end
            WAIT: begin
              if (imem_rvalid) begin
                state_n = FETCH;
              end else begin
                kill_n = 1'b1;
              end
            end
            default: state_n = FETCH;
          endcase
        end
      end else if (halt && instr_valid && !stall) begin
        halted_n = 1'b1;
        state_n  = HALTED;
      end else begin
        case (state)
          FETCH: begin
            if (hs_c) begin
              req_pc_n = pc;
              state_n  = WAIT;
            end
          end
          WAIT: begin
            if (imem_rvalid) begin
              if (kill) begin
                kill_n  = 1'b0;
                state_n = FETCH;
              end else if (slot_free_c) begin
                instr_n    = imem_rdata;
                instr_pc_n = req_pc;
                valid_n    = 1'b1;
                pc_n       = PC_W'(req_pc + PC_W'(2));
                state_n    = FETCH;
              end else begin
                skid_n  = imem_rdata;
                state_n = HOLD;
              end
            end
          end
          HOLD: begin
            if (!stall) begin
              instr_n    = skid;
              instr_pc_n = req_pc;
              valid_n    = 1'b1;
              pc_n       = PC_W'(req_pc + PC_W'(2));
              state_n    = FETCH;
            end
          end
          default: ;
        endcase
      end
    end

    pc_plus2_n = PC_W'(instr_pc_n + PC_W'(2));
    req_n      = (state_n == FETCH);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic against a stream-level model of
// fetch_unit (in-order address stream, epoch-tagged memory responses, halt/redirect flags).
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req, imem_rdy, imem_rvalid;
  logic [15:0] imem_addr, imem_rdata;
  logic        stall, redirect_valid, halt;
  logic [15:0] redirect_pc;
  logic [15:0] instr, instr_pc, pc_plus2;
  logic [4:0]  opcode;
  logic [1:0]  lower_two;
  logic        instr_valid, halted, err;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .instr(instr), .instr_pc(instr_pc), .pc_plus2(pc_plus2), .opcode(opcode),
    .lower_two(lower_two), .instr_valid(instr_valid), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Memory image and responder settings.
  logic [15:0] mem [256];
  bit          rdy_rand = 1'b0;
  int unsigned lat_min = 1, lat_max = 1;
  bit          pending = 1'b0;
  logic [15:0] pend_addr;
  int          pend_epoch, cnt;
  logic [15:0] resp_addr = '0;
  bit          resp_live = 1'b0;

  // Reference model state.
  int          epoch = 0;
  logic [15:0] exp_req = '0, exp_con = '0;
  bit          m_halted = 1'b0, m_err = 1'b0;
  bit          prev_flush = 1'b0, prev_valid = 1'b0, prev_stall = 1'b0, prev_live = 1'b0;
  logic [15:0] prev_pc = '0, prev_raddr = '0;
  logic [15:0] stall_at = 16'hFFFF, halt_at = 16'hFFFF;
  int          stall_hold = 0;
  int          n_cons = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction memory: one outstanding read, random accept and latency >= 1 cycle.
  initial begin
    imem_rdy = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = 16'($urandom);
      if (pending) begin
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem[pend_addr[8:1]];
          resp_addr   = pend_addr;
          resp_live   = (pend_epoch == epoch);
          pending     = 1'b0;
        end else begin
          cnt--;
        end
      end
      imem_rdy = rdy_rand ? ($urandom_range(0, 99) < 70) : 1'b1;
      if (imem_req === 1'b1 && imem_rdy && rst_n) begin
        pending    = 1'b1;
        pend_addr  = imem_addr;
        pend_epoch = epoch;
        cnt        = int'($urandom_range(lat_max, lat_min)) - 1;
      end
    end
  end

  task automatic step(input bit st, input bit rv, input logic [15:0] rp);
    bit          st_e, hl, bad_al;
    logic [15:0] w;
    @(negedge clk); #1;
    chk("err", err, m_err);
    chk("pc_plus2", pc_plus2, 16'(instr_pc + 16'd2));
    if (m_halted) begin
      chk("halted", halted, 1);
      chk("halted_req", imem_req, 0);
      chk("halted_valid", instr_valid, 0);
    end else begin
      chk("not_halted", halted, 0);
      if (prev_flush) chk("flush_valid", instr_valid, 0);
      else if (prev_valid && prev_stall) begin
        chk("hold_valid", instr_valid, 1);
        chk("hold_pc", instr_pc, prev_pc);
      end else if (prev_live) begin
        chk("resp_valid", instr_valid, 1);
        chk("resp_pc", instr_pc, prev_raddr);
      end
      if (instr_valid) chk("order_pc", instr_pc, exp_con);
      if (imem_req && imem_rdy) begin
        chk("req_addr", imem_addr, exp_req);
        exp_req = exp_req + 16'd2;
      end
    end
    if (instr_valid) begin
      w = mem[instr_pc[8:1]];
      chk("instr", instr, w);
      chk("opcode", opcode, w[15:11]);
      chk("lower_two", lower_two, w[1:0]);
    end else begin
      chk("instr_nop", instr, NOP);
      chk("opcode_nop", opcode, 5'b00001);
    end
    // Drive decode/execute side for the next edge.
    st_e = st | (stall_hold > 0 && instr_valid && instr_pc == stall_at);
    if (st_e && !st) stall_hold--;
    hl = instr_valid && instr_pc == halt_at;
    stall = st_e; redirect_valid = rv; redirect_pc = rp; halt = hl;
    prev_flush = 1'b0;
    prev_live  = imem_rvalid && resp_live && !m_halted && (!instr_valid || !st_e);
    prev_raddr = resp_addr;
    prev_valid = instr_valid; prev_stall = st_e; prev_pc = instr_pc;
    if (!m_halted) begin
      if (instr_valid && !st_e) begin
        exp_con = exp_con + 16'd2;
        n_cons++;
      end
      if (rv) begin
        prev_flush = 1'b1; prev_live = 1'b0; epoch++;
`ifdef FETCH_ALIGN_CHK_EN
        bad_al = rp[0];
`else
        bad_al = 1'b0;
`endif
        if (bad_al) begin
          m_halted = 1'b1; m_err = 1'b1;
        end else begin
          exp_req = rp & 16'hFFFE; exp_con = rp & 16'hFFFE;
        end
      end else if (hl && !st_e) begin
        m_halted = 1'b1; prev_live = 1'b0;
      end
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk); #1;
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    m_halted = 1'b0; m_err = 1'b0; exp_req = '0; exp_con = '0; epoch++;
    prev_flush = 1'b0; prev_valid = 1'b0; prev_stall = 1'b0; prev_live = 1'b0;
    repeat (n) begin
      @(negedge clk); #1;
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 16'h0000);
      chk("rst_valid", instr_valid, 0);
      chk("rst_instr", instr, NOP);
      chk("rst_instr_pc", instr_pc, 0);
      chk("rst_halted", halted, 0);
      chk("rst_err", err, 0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    bit found;
    int n0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8] = 16'hD805;

    // Sequential fetch, then a 3-cycle stall on the D805 word at 0x0010.
    stall_at = 16'h0010; stall_hold = 3;
    do_reset(3);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, '0);
    chk("stall_seq_done", stall_hold, 0);
    chk("stall_seq_progress", (exp_con > 16'h0014), 1);

    // Redirect to 0x0040 while waiting on the 0x0006 response.
    do_reset(2);
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      step(1'b0, 1'b0, '0);
      found = imem_req && imem_rdy && imem_addr == 16'h0006;
    end
    chk("redir_wait_found", found, 1);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 16'h0040);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1'b0, 1'b0, '0);
      found = instr_valid && instr_pc == 16'h0040;
    end
    chk("redir_target_seen", found, 1);

    // Halt at 0x000A; stays halted through stalls and a redirect.
    do_reset(2);
    lat_min = 1; lat_max = 3; halt_at = 16'h000A;
    for (int i = 0; i < 80 && !m_halted; i++) step(1'b0, 1'b0, '0);
    chk("halt_reached", m_halted, 1);
    halt_at = 16'hFFFF;
    for (int i = 0; i < 20; i++) step(($urandom_range(0, 1) == 1), (i == 5), 16'h0020);

    // Reset while a response is outstanding; it lands during reset.
    do_reset(2);
    lat_min = 4; lat_max = 4;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b0, '0);
      found = imem_req && imem_rdy;
    end
    chk("rst_mid_found", found, 1);
    do_reset(5);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0);

    // Odd redirect target.
    do_reset(2);
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 16'h0043);
    found = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, '0);
      if (instr_valid && instr_pc == 16'h0042) found = 1'b1;
    end
`ifdef FETCH_ALIGN_CHK_EN
    chk("misalign_err", err, 1);
    chk("misalign_halted", halted, 1);
    chk("misalign_no_fetch", found, 0);
`else
    chk("misalign_err", err, 0);
    chk("misalign_fetch_42", found, 1);
`endif

    // PC wrap 0xFFFE -> 0x0000.
    do_reset(2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 16'hFFFC);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, '0);
      if (instr_valid && instr_pc == 16'hFFFE) chk("wrap_plus2", pc_plus2, 16'h0000);
      if (instr_valid && instr_pc == 16'h0000) found = 1'b1;
    end
    chk("wrap_seen_0", found, 1);

    // Random back-pressure, latency and redirects.
    do_reset(2);
    rdy_rand = 1'b1; lat_min = 1; lat_max = 4;
    n0 = n_cons;
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] rp;
      rp = ($urandom_range(0, 9) == 0) ? 16'hFFFC : 16'($urandom_range(0, 255) * 2);
      step(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 3), rp);
    end
    chk("rand_progress", ((n_cons - n0) > 100), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
